// File: rtl/mt_stream_gen.sv
// ============================================================================
// Module      : mt_stream_gen
// Description : Streaming Mersenne-Twister PRNG (MT19937-32 / MT19937-64 by
//               parameter set). The twist is computed on the fly for each
//               output word, so there is no N-cycle regeneration stall.
//               Words leave on a valid/ready stream. A reseed can be issued
//               at any time.
// Ports       : clk        - clock, all state on rising edge
//               rst_n      - asynchronous active-low reset
//               seed_valid - one-cycle strobe, restart with seed
//               seed       - new seed (W bits), sampled with seed_valid
//               out_valid  - out_data holds an untaken random word
//               out_ready  - consumer accepts when out_valid & out_ready
//               out_data   - tempered random word (W bits)
//               busy       - high while the state array is being filled
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mt_stream_gen #(
    parameter int             W            = 32,
    parameter int             N            = 624,
    parameter int             M            = 397,
    parameter int             R            = 31,
    parameter logic [W-1:0]   A            = W'(32'h9908B0DF),
    parameter int             U            = 11,
    parameter logic [W-1:0]   D            = W'(32'hFFFFFFFF),
    parameter int             S            = 7,
    parameter logic [W-1:0]   B            = W'(32'h9D2C5680),
    parameter int             T            = 15,
    parameter logic [W-1:0]   C            = W'(32'hEFC60000),
    parameter int             L            = 18,
    parameter logic [W-1:0]   F            = W'(32'd1812433253),
    parameter logic [W-1:0]   DEFAULT_SEED = W'(32'd5489)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_valid,
    input  logic [W-1:0] seed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    localparam int                 c_idx_w   = $clog2(N);
    localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(N - 1);
    localparam logic [c_idx_w-1:0] c_m       = c_idx_w'(M);
    localparam logic [c_idx_w-1:0] c_wrap_m  = c_idx_w'(N - M);
    localparam logic [W-1:0]       c_lower   = {W{1'b1}} >> (W - R);
    localparam logic [W-1:0]       c_upper   = ~c_lower;
    localparam logic [W-1:0]       c_one     = W'(1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_st;
    logic [c_idx_w-1:0]   r_idx;
    logic [W-1:0]         r_x;
    logic                 r_out_valid;
    logic [W-1:0]         r_out_data;
    logic [W-1:0]         r_mt [N];

    logic                 w_last;
    logic [c_idx_w-1:0]   w_idx_p1;
    logic [c_idx_w-1:0]   w_idx_pm;
    logic [W-1:0]         w_y;
    logic [W-1:0]         w_v;
    logic [W-1:0]         w_x_next;
    logic                 w_take;
    logic                 w_mt_we;
    logic [W-1:0]         w_mt_wd;

    function automatic logic [W-1:0] f_temper(input logic [W-1:0] y_in);
        logic [W-1:0] y;
        y = y_in;
        y = y ^ ((y >> U) & D);
        y = y ^ ((y << S) & B);
        y = y ^ ((y << T) & C);
        y = y ^ (y >> L);
        return y;
    endfunction

    // Neighbour indices, modulo N without a divider.
    assign w_last   = (r_idx == c_last);
    assign w_idx_p1 = w_last ? '0 : r_idx + 1'b1;
    assign w_idx_pm = (r_idx >= c_wrap_m) ? r_idx - c_wrap_m : r_idx + c_m;

    // Twist for the current index. All three reads see the array as it was
    // before this edge; the reference ordering (mt[0] already replaced when
    // idx=N-1, upper half of the array replaced when idx+M wraps) therefore
    // falls out naturally without forwarding.
    assign w_y = (r_mt[r_idx] & c_upper) | (r_mt[w_idx_p1] & c_lower);
    assign w_v = r_mt[w_idx_pm] ^ (w_y >> 1) ^ (w_y[0] ? A : '0);

    // Initialisation chain: next value from the one just written at r_idx.
    assign w_x_next = F * (r_x ^ (r_x >> (W - 2)))
                      + {{(W - c_idx_w){1'b0}}, r_idx} + c_one;

    assign w_take  = (r_st == ST_RUN) && (!r_out_valid || out_ready);

    // A reseed on the same edge suppresses any array write.
    assign w_mt_we = rst_n && !seed_valid && ((r_st == ST_INIT) || w_take);
    assign w_mt_wd = (r_st == ST_INIT) ? r_x : w_v;

    // State array is deliberately not reset; it is always refilled in INIT.
    always_ff @(posedge clk) begin
        if (w_mt_we) begin
            r_mt[r_idx] <= w_mt_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st        <= ST_INIT;
            r_idx       <= '0;
            r_x         <= DEFAULT_SEED;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (seed_valid) begin
            // Reseed wins over everything, including a handshake this edge.
            r_st        <= ST_INIT;
            r_idx       <= '0;
            r_x         <= seed;
            r_out_valid <= 1'b0;
        end else begin
            case (r_st)
                ST_INIT: begin
                    r_x <= w_x_next;
                    if (w_last) begin
                        r_st  <= ST_RUN;
                        r_idx <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_take) begin
                        r_out_data  <= f_temper(w_v);
                        r_out_valid <= 1'b1;
                        r_idx       <= w_idx_p1;
                    end
                end
                default: begin
                    r_st <= ST_INIT;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_st == ST_INIT);

endmodule

`default_nettype wire

// File: tb/tb_mt_stream_gen.sv
// ============================================================================
// Module      : tb_mt_stream_gen
// Description : Self-checking bench for mt_stream_gen. Directed vector table
//               of {seed, word number, expected word}, plus hand-written
//               sequences for latency, back-pressure, reseed and async reset.
//               A small batch-style reference MT19937-32 supplies the golden
//               stream for the back-pressure run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mt_stream_gen;

    localparam int N   = 624;
    localparam int N64 = 312;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_valid;
    logic [31:0] seed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    logic        out_valid64;
    logic [63:0] out_data64;
    logic        busy64;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mt_stream_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed       (seed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    mt_stream_gen #(
        .W            (64),
        .N            (312),
        .M            (156),
        .R            (31),
        .A            (64'hB5026F5AA96619E9),
        .U            (29),
        .D            (64'h5555555555555555),
        .S            (17),
        .B            (64'h71D67FFFEDA60000),
        .T            (37),
        .C            (64'hFFF7EEE000000000),
        .L            (43),
        .F            (64'd6364136223846793005),
        .DEFAULT_SEED (64'd5489)
    ) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (1'b0),
        .seed       (64'd0),
        .out_valid  (out_valid64),
        .out_ready  (1'b1),
        .out_data   (out_data64),
        .busy       (busy64)
    );

    // ---------------- reference MT19937-32 (batch form) ----------------
    logic [31:0] gm [N];
    int          gi;

    function automatic void gm_seed(input logic [31:0] s);
        gm[0] = s;
        for (int i = 1; i < N; i++) begin
            gm[i] = 32'd1812433253 * (gm[i-1] ^ (gm[i-1] >> 30)) + 32'(i);
        end
        gi = N;
    endfunction

    function automatic logic [31:0] gm_next();
        logic [31:0] y;
        if (gi >= N) begin
            for (int kk = 0; kk < N; kk++) begin
                y = (gm[kk] & 32'h80000000) | (gm[(kk + 1) % N] & 32'h7FFFFFFF);
                gm[kk] = gm[(kk + 397) % N] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
            end
            gi = 0;
        end
        y  = gm[gi];
        gi = gi + 1;
        y  = y ^ (y >> 11);
        y  = y ^ ((y << 7)  & 32'h9D2C5680);
        y  = y ^ ((y << 15) & 32'hEFC60000);
        y  = y ^ (y >> 18);
        return y;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Entered at a negedge with fresh outputs; accepts one word and returns
    // at the negedge after the consuming edge. waits = idle cycles seen.
    task automatic next_word(output logic [31:0] w, output int waits);
        out_ready = 1'b1;
        w         = '0;
        waits     = 0;
        while (!out_valid && waits < N + 20) begin
            @(negedge clk);
            waits++;
        end
        if (out_valid) begin
            w = out_data;
            @(negedge clk);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL next_word timeout: no out_valid within %0d cycles", N + 20);
        end
    endtask

    task automatic seed_pulse(input logic [31:0] s);
        seed_valid = 1'b1;
        seed       = s;
        @(negedge clk);
        seed_valid = 1'b0;
    endtask

    // Counts cycles until busy drops (bounded).
    task automatic busy_len(output int cnt);
        cnt = 0;
        while (busy && cnt < N + 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    typedef struct {
        logic [31:0] seed;
        int          nth;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [31:0] w;
        logic [31:0] held;
        logic [31:0] expw;
        logic [63:0] w64;
        int          waits;
        int          gap;
        int          cnt;
        int          busy_edge;
        int          valid_edge;
        int          v64_edge;
        int          b64_edge;
        int          acc;
        int          cyc;
        bit          stalled;

        vecs[0] = '{32'd5489, 1,     32'd3499211612};
        vecs[1] = '{32'd5489, 2,     32'd581869302};
        vecs[2] = '{32'd5489, 10000, 32'd4123659995};
        vecs[3] = '{32'd1,    1,     32'd1791095845};

        rst_n      = 1'b0;
        seed_valid = 1'b0;
        seed       = '0;
        out_ready  = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset busy",      {63'd0, busy},      64'd1);
        check("reset out_data",  {32'd0, out_data},  64'd0);

        // ---- latency after reset release, plus 64-bit first word ----
        rst_n      = 1'b1;
        out_ready  = 1'b1;
        busy_edge  = -1;
        valid_edge = -1;
        v64_edge   = -1;
        b64_edge   = -1;
        w64        = '0;
        for (int k = 1; k <= N + 1; k++) begin
            @(negedge clk);
            if (busy_edge < 0 && !busy)        busy_edge  = k;
            if (valid_edge < 0 && out_valid)   valid_edge = k;
            if (b64_edge < 0 && !busy64)       b64_edge   = k;
            if (v64_edge < 0 && out_valid64) begin
                v64_edge = k;
                w64      = out_data64;
            end
        end
        check("busy low after N edges",      64'(busy_edge),  64'(N));
        check("out_valid after N+1 edges",   64'(valid_edge), 64'(N + 1));
        check("w64 busy low edge",           64'(b64_edge),   64'(N64));
        check("w64 first word edge",         64'(v64_edge),   64'(N64 + 1));
        check("w64 first word",              w64,             64'd14514284786278117030);

        next_word(w, waits);
        check("after reset word1", {32'd0, w}, 64'd3499211612);
        next_word(w, waits);
        check("after reset word2", {32'd0, w}, 64'd581869302);
        check("after reset word2 no gap", 64'(waits), 64'd0);

        // ---- vector table: reseed, draw nth word ----
        for (int v = 0; v < 4; v++) begin
            seed_pulse(vecs[v].seed);
            gap = 0;
            w   = '0;
            for (int j = 1; j <= vecs[v].nth; j++) begin
                next_word(w, waits);
                if (j > 1) gap += waits;
            end
            check($sformatf("vec%0d seed %0d word %0d", v, vecs[v].seed, vecs[v].nth),
                  {32'd0, w}, {32'd0, vecs[v].exp});
            check($sformatf("vec%0d no bubble", v), 64'(gap), 64'd0);
        end

        // ---- back-pressure against reference model ----
        gm_seed(32'h12345678);
        seed_pulse(32'h12345678);
        acc     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (acc < 3 * N + 10 && cyc < 20 * N) begin
            if (stalled) begin
                check("stall out_valid held", {63'd0, out_valid}, 64'd1);
                check("stall out_data stable", {32'd0, out_data}, {32'd0, held});
            end
            out_ready = ($urandom_range(0, 9) >= 3);
            if (out_valid && out_ready) begin
                expw = gm_next();
                check($sformatf("bp word %0d", acc), {32'd0, out_data}, {32'd0, expw});
                acc++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            @(negedge clk);
            cyc++;
        end
        check("bp words accepted", 64'(acc), 64'(3 * N + 10));

        // ---- reseed mid-RUN while a word is held ----
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        @(negedge clk);
        check("held before reseed valid", {63'd0, out_valid}, 64'd1);
        check("held before reseed data",  {32'd0, out_data},  {32'd0, held});
        seed_pulse(32'd1);
        check("reseed drops out_valid", {63'd0, out_valid}, 64'd0);
        check("reseed sets busy",       {63'd0, busy},      64'd1);
        busy_len(cnt);
        check("reseed busy length", 64'(cnt), 64'(N));
        next_word(w, waits);
        check("reseed seed1 word1", {32'd0, w}, 64'd1791095845);
        check("reseed first word latency", 64'(waits), 64'd1);

        // ---- reseed during INIT, then reseed on a handshake edge ----
        seed_pulse(32'd7);
        repeat (100) @(negedge clk);
        check("mid-INIT busy", {63'd0, busy}, 64'd1);
        seed_pulse(32'd5489);
        busy_len(cnt);
        check("INIT restart busy length", 64'(cnt), 64'(N));
        next_word(w, waits);
        check("INIT restart word1", {32'd0, w}, 64'd3499211612);
        out_ready = 1'b1;
        check("handshake edge valid", {63'd0, out_valid}, 64'd1);
        seed_pulse(32'd1);
        check("seed beats handshake", {63'd0, out_valid}, 64'd0);
        next_word(w, waits);
        check("after handshake reseed word1", {32'd0, w}, 64'd1791095845);

        // ---- asynchronous reset mid-stream ----
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {63'd0, out_valid}, 64'd0);
        check("async rst busy",      {63'd0, busy},      64'd1);
        check("async rst out_data",  {32'd0, out_data},  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_word(w, waits);
        check("after async rst word1", {32'd0, w}, 64'd3499211612);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
